// File: rtl/mult_booth_unit.sv
// Multicycle radix-2 Booth multiplier for MULT/MULTU. Operands are extended by one
// bit so signed and unsigned products share one datapath; result lands in Hi/Lo.
module mult_booth_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int P_W = 2 * (WIDTH + 1) + 1;
    localparam int CW  = $clog2(ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] ITER_C = CW'(ITER);

    // One Booth step: add/subtract on the upper half, then arithmetic shift right.
    function automatic logic [P_W-1:0] booth_step(input logic [P_W-1:0] p,
                                                  input logic [WIDTH:0] mcand);
        logic [WIDTH:0] upper;
        upper = p[P_W-1:WIDTH+2];
        case (p[1:0])
            2'b01:   upper = upper + mcand;
            2'b10:   upper = upper - mcand;
            default: upper = p[P_W-1:WIDTH+2];
        endcase
        return {upper[WIDTH], upper, p[WIDTH+1:1]};
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH:0]   r_mcand;
    logic [P_W-1:0]   r_p;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_mcand_ext;
    logic [WIDTH:0]   w_mplr_ext;
    logic [P_W-1:0]   w_p_step;

    // Operand extension and next Booth step value.
    always_comb begin
        w_mcand_ext = {Signed & OpA[WIDTH-1], OpA};
        w_mplr_ext  = {Signed & OpB[WIDTH-1], OpB};
        w_p_step    = booth_step(r_p, r_mcand);
    end

    // Control FSM, Booth datapath and result registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_mcand <= w_mcand_ext;
                        r_p     <= {{(WIDTH + 1){1'b0}}, w_mplr_ext, 1'b0};
                        r_cnt   <= ITER_C;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_step;
                    r_cnt <= r_cnt - CW'(1);
                    // Last step: low 2*WIDTH bits of the extended product go to Hi/Lo.
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= w_p_step[2*WIDTH:WIDTH+1];
                        r_lo    <= w_p_step[WIDTH:1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: doc/mult_booth_unit.md
Name: mult_booth_unit

Overview:
- Multicycle radix-2 Booth multiplier for MULT and MULTU.
- Sits directly downstream of the datapath A/B operand registers and consumes a_output/b_output.
- Produces the 64-bit product in HI/LO registers; the datapath reads these on MFHI/MFLO.
- Uses a start/done handshake with the control unit, which stalls in a wait state until Done.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
ITER, WIDTH+1, Booth steps; operands are extended by one bit so signed and unsigned share one datapath.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  one clock; reset is synchronous and active-low (Reset=0 sampled at a Clk edge resets the block).
Start  input  1  request; sampled only in IDLE or DONE.
Signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with Start.
OpA  input  WIDTH  multiplicand (from A register); captured with Start.
OpB  input  WIDTH  multiplier (from B register); captured with Start.
Busy  output  1  high while in RUN.
Done  output  1  one-cycle pulse; Hi/Lo valid and updated.
Hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
Lo  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- States: IDLE, RUN, DONE. Reset value is IDLE; Busy=0, Done=0, Hi=0, Lo=0, counter=0, internal registers cleared.
- Reset has priority over every other event. Reset low in any state, including mid-RUN, forces the reset values at that edge. A partial result is discarded and never appears on Hi/Lo.
- IDLE or DONE with Start=1 at edge k:
  - Operand extension: MCAND = {Signed&OpA[31], OpA}; MPLR = {Signed&OpB[31], OpB}, each WIDTH+1 bits.
  - Product register P (2*(WIDTH+1)+1 bits) loads {zeros(WIDTH+1), MPLR, 1'b0}.
  - Counter loads ITER; state becomes RUN.
- IDLE or DONE with Start=0: DONE goes to IDLE; IDLE stays IDLE.
- RUN step, once per edge:
  - Examine P[1:0]. 01: upper half += MCAND. 10: upper half -= MCAND. 00/11: no add.
  - Add/subtract is WIDTH+1 bits, modulo, carry discarded.
  - Then arithmetic-shift P right by 1, replicating the MSB.
  - Decrement counter.
- Final step is the step taken when counter==1, at edge k+ITER (k+33):
  - Hi/Lo load P[2*WIDTH:1], i.e. the low 64 bits of the 66-bit result.
  - State becomes DONE.
- Latency: Done is high exactly in the cycle after edge k+33; Busy is high for the 33 cycles after edge k.
- Hi/Lo change only at the final step (or reset). They hold their value across IDLE and across a new RUN until that RUN completes.
- Start while in RUN is ignored: no restart, and OpA/OpB/Signed changes have no effect.
- Start asserted in DONE starts the next operation back-to-back. Done still pulses exactly one cycle.
- Done and Busy are never high together.
- No overflow flag: a 64-bit product cannot overflow.

Test Plan:
1. Reset=0 for 2 edges, then release -> Hi=0, Lo=0, Busy=0, Done=0; Start=0 keeps IDLE indefinitely.
2. Signed=1, OpA=3, OpB=4, Start pulse at edge k -> Busy=1 for 33 cycles; Done=1 in cycle after edge k+33 only; Hi=0x00000000, Lo=0x0000000C.
3. Signed=1: OpA=0xFFFFFFFF, OpB=0x00000001 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF. Signed=1: OpA=OpB=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
4. OpA=OpB=0xFFFFFFFF:
   - Signed=0 -> Hi=0xFFFFFFFE, Lo=0x00000001.
   - Signed=1 -> Hi=0x00000000, Lo=0x00000001.
5. Start with 7*6, then at edge k+10 pulse Start with OpA=2, OpB=2 -> second Start ignored; Hi/Lo=0/42 at k+33. Holding Start=1 in DONE with OpA=5, OpB=5 -> a second run begins; Done pulses again at k+67 with Lo=25.
6. Start 7*6 after a prior result of 25. At edge k+20 set Reset=0 for one edge -> IDLE, Busy=0, Hi=Lo=0, no Done pulse. A following Start with 2*2 completes normally with Lo=4.
